// File: rtl/onehot_dec_pkg.sv
// Shared types for the sequential one-hot decoder: mode/state encodings and a one-hot helper.
// Combinational helpers only; no latency, no backpressure.
package onehot_dec_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        DECODE    = 2'd0,
        SCAN_UP   = 2'd1,
        SCAN_DOWN = 2'd2,
        HOLD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        return MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_dwell_timer.sv
// Dwell timer: counts enabled cycles and pulses tick when the count reaches the latched dwell.
// tick is combinational from the count; a frozen enable holds the count (no backpressure).
module dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] dwell_lat;

    assign tick = enable && (count == dwell_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            dwell_lat <= '0;
        end else if (load) begin
            count     <= '0;
            dwell_lat <= dwell;
        end else if (enable) begin
            count <= tick ? '0 : count + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with autonomous up/down scan and output enable.
// Latency 1 cycle from accept; in_ready drops while a scan is running or paused.
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    wrap,
    output logic                    busy
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    state_e             state, state_nxt;
    mode_e              mode_s;
    logic               dir_up, dir_up_nxt;
    logic               lit, lit_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [OUT_W-1:0]   out_nxt;
    logic               wrap_nxt;
    logic               scan_mode;
    logic               accept;
    logic               tick;

    assign mode_s    = mode_e'(mode);
    assign scan_mode = (mode_s == SCAN_UP) || (mode_s == SCAN_DOWN);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready && en;

    // Timer only advances on enabled cycles that keep the scan running, so
    // both en=0 and HOLD freeze the count where it stands.
    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && scan_mode),
        .enable (en && busy && scan_mode),
        .dwell  (dwell),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = out_idx;
        dir_up_nxt = dir_up;
        lit_nxt    = lit;
        wrap_nxt   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (accept && (mode_s != HOLD)) begin
                        idx_nxt = in;
                        lit_nxt = 1'b1;
                        if (scan_mode) begin
                            dir_up_nxt = (mode_s == SCAN_UP);
                            state_nxt  = SCAN;
                        end
                    end
                end
                SCAN, PAUSE: begin
                    case (mode_s)
                        DECODE:  state_nxt = IDLE;
                        HOLD:    state_nxt = PAUSE;
                        default: begin
                            // Direction comes from the latch, never from the live mode.
                            state_nxt = SCAN;
                            if (tick) begin
                                idx_nxt  = dir_up ? out_idx + SEL_W'(1) : out_idx - SEL_W'(1);
                                wrap_nxt = dir_up ? (&out_idx) : ~(|out_idx);
                            end
                        end
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
        // lit stays low until the first accept so reset leaves out all-zero.
        out_nxt = (en && lit_nxt) ? OUT_W'(onehot(MAX_SEL_W'(idx_nxt))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            out_idx <= '0;
            wrap    <= 1'b0;
            dir_up  <= 1'b1;
            lit     <= 1'b0;
        end else begin
            out     <= out_nxt;
            out_idx <= idx_nxt;
            wrap    <= wrap_nxt;
            dir_up  <= dir_up_nxt;
            lit     <= lit_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Randomized plus directed bench for onehot_decoder_seq with a queue-based scoreboard.
module tb_onehot_decoder_seq;

    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [7:0] dwell;
    logic [7:0] out;
    logic [2:0] out_idx;
    logic       wrap;
    logic       busy;

    onehot_decoder_seq #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_idx),
        .dwell    (dwell),
        .out      (out),
        .out_idx  (out_idx),
        .wrap     (wrap),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        logic       busy;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   wrap_seen = 0;

    // Reference model: 0 = idle, 1 = scanning, 2 = paused.
    int m_phase, m_idx, m_dir, m_elapsed, m_period;
    bit m_lit, m_wrap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_dir = 1; m_elapsed = 0; m_period = 1;
        m_lit = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int nxt;
        m_wrap = 0;
        if (en) begin
            if (m_phase == 0) begin
                if (in_valid && mode != 2'd3) begin
                    m_idx = int'(in_idx);
                    m_lit = 1;
                    if (mode != 2'd0) begin
                        m_dir = (mode == 2'd1) ? 1 : -1;
                        m_period = int'(dwell) + 1;
                        m_elapsed = 0;
                        m_phase = 1;
                    end
                end
            end else if (mode == 2'd0) begin
                m_phase = 0;
            end else if (mode == 2'd3) begin
                m_phase = 2;
            end else begin
                m_phase = 1;
                m_elapsed++;
                if (m_elapsed == m_period) begin
                    m_elapsed = 0;
                    nxt = (m_idx + m_dir + N) % N;
                    m_wrap = (m_dir == 1 && nxt == 0) || (m_dir == -1 && nxt == N - 1);
                    m_idx = nxt;
                end
            end
        end
    endtask

    task automatic tick_cycle();
        exp_t e;
        model_step();
        e.out  = (en && m_lit) ? 8'(1 << m_idx) : 8'd0;
        e.idx  = 3'(m_idx);
        e.wrap = m_wrap;
        e.busy = (m_phase != 0);
        e.rdy  = (m_phase == 0);
        @(posedge clk);
        q.push_back(e);
        #2;
    endtask

    task automatic drive(input logic e_, input logic [1:0] m_, input logic v_,
                         input int i_, input int d_, input int n);
        en = e_; mode = m_; in_valid = v_; in_idx = 3'(i_); dwell = 8'(d_);
        for (int k = 0; k < n; k++) tick_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out"}, 64'(out), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_wrap"}, 64'(wrap), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    // Monitor: every cycle is an output beat; pop and compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out", 64'(out), 64'(e.out));
                chk("out_idx", 64'(out_idx), 64'(e.idx));
                chk("wrap", 64'(wrap), 64'(e.wrap));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("in_ready", 64'(in_ready), 64'(e.rdy));
                if (wrap === 1'b1) wrap_seen++;
            end
        end
    end

    initial begin
        int w0;
        logic [1:0] cur_mode;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; in_valid = 1'b0; in_idx = '0; dwell = '0;
        model_reset();
        #3;
        check_reset_values("reset");
        @(posedge clk); #1; rst_n = 1'b1; #1;

        // Decode sweep 0..7 on consecutive cycles.
        for (int i = 0; i < N; i++) drive(1'b1, 2'd0, 1'b1, i, 0, 1);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 2);

        // Scan up from 6 with dwell 2: one wrap expected.
        drive(1'b1, 2'd1, 1'b1, 6, 2, 1);
        w0 = wrap_seen;
        drive(1'b1, 2'd1, 1'b0, 0, 0, 11);
        @(negedge clk); #1;
        chk("wrap_once", 64'(wrap_seen - w0), 64'd1);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 1);

        // Scan down from 1, dwell 0, pause, resume with the other scan mode.
        drive(1'b1, 2'd2, 1'b1, 1, 0, 1);
        drive(1'b1, 2'd2, 1'b0, 0, 0, 2);
        drive(1'b1, 2'd3, 1'b0, 0, 0, 4);
        drive(1'b1, 2'd1, 1'b0, 0, 0, 2);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 1);

        // Enable gating mid-scan.
        drive(1'b1, 2'd1, 1'b1, 3, 4, 1);
        drive(1'b1, 2'd1, 1'b0, 0, 0, 2);
        drive(1'b0, 2'd1, 1'b0, 0, 0, 5);
        drive(1'b1, 2'd1, 1'b0, 0, 0, 8);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 1);

        // Abort mid-scan then decode a fresh index.
        drive(1'b1, 2'd1, 1'b1, 5, 3, 1);
        drive(1'b1, 2'd1, 1'b0, 0, 0, 2);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 1);
        drive(1'b1, 2'd0, 1'b1, 2, 0, 1);
        drive(1'b1, 2'd0, 1'b0, 0, 0, 1);

        // Asynchronous reset mid-scan.
        drive(1'b1, 2'd1, 1'b1, 4, 1, 1);
        drive(1'b1, 2'd1, 1'b0, 0, 0, 3);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check_reset_values("midscan_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;

        // Random traffic with sticky modes.
        cur_mode = 2'd0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) cur_mode = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 15) != 0), cur_mode, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), 1);
        end

        @(negedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
